sram_responder: RTL



---
 rtl/sram_responder_pkg.sv | 49 ++++
 rtl/sram_responder_mmio_regs.sv | 73 +++++++
 rtl/sram_responder.sv | 91 +++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// Shared constants and helpers for the SRAM-like responder: MMIO register map,
// kseg0/kseg1 address translation and byte-enable merging.
package sram_responder_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1faf_0000;
    localparam logic [31:0] KSEG_MASK         = 32'h1fff_ffff;

    localparam logic [15:0] LED_OFF   = 16'h0000;
    localparam logic [15:0] TIMER_OFF = 16'h0004;
    localparam logic [15:0] NUM_OFF   = 16'h0008;
    localparam logic [15:0] EXIT_OFF  = 16'h000c;

    typedef enum logic [2:0] {
        REG_LED,
        REG_TIMER,
        REG_NUM,
        REG_EXIT,
        REG_NONE
    } mmio_reg_e;

    // kseg0 and kseg1 both map onto the low 512 MB of physical space.
    function automatic logic [31:0] kseg_translate(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  wen);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    function automatic mmio_reg_e decode_off(input logic [15:0] off);
        mmio_reg_e r;
        case (off)
            LED_OFF:   r = REG_LED;
            TIMER_OFF: r = REG_TIMER;
            NUM_OFF:   r = REG_NUM;
            EXIT_OFF:  r = REG_EXIT;
            default:   r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_responder_mmio_regs.sv
// MMIO register window: LED, free-running TIMER, NUM display and sticky SIM_EXIT.
// Read value is combinational from the current (pre-edge) register state.
module sram_responder_mmio_regs
    import sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] off,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        sim_done
);

    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] num_q, num_d;
    logic        done_q, done_d;
    mmio_reg_e   sel;
    logic [31:0] led_merged;

    always_comb begin
        sel        = decode_off(off);
        led_merged = byte_merge({16'b0, led_q}, wdata, {2'b00, wen[1:0]});
        led_d      = led_q;
        timer_d    = timer_q + 32'd1;
        num_d      = num_q;
        done_d     = done_q;
        if (wr_en) begin
            case (sel)
                REG_LED:   led_d   = led_merged[15:0];
                // A write replaces this cycle's increment.
                REG_TIMER: timer_d = byte_merge(timer_q, wdata, wen);
                REG_NUM:   num_d   = byte_merge(num_q, wdata, wen);
                REG_EXIT:  done_d  = 1'b1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            REG_LED:   rd_data = {16'b0, led_q};
            REG_TIMER: rd_data = timer_q;
            REG_NUM:   rd_data = num_q;
            REG_EXIT:  rd_data = {31'b0, done_q};
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            timer_q <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
            num_q   <= num_d;
            done_q  <= done_d;
        end
    end

    assign led      = led_q;
    assign num_data = num_q;
    assign sim_done = done_q;

endmodule

// File: rtl/sram_responder.sv
// Responder for the core's instruction/data SRAM-like ports: address translation,
// word RAM with byte-enabled writes, MMIO window, one-cycle registered read data.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        sim_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       inst_phys, data_phys;
    logic [ADDR_W-1:0] inst_idx, data_idx;
    logic              inst_mmio, data_mmio;
    logic              data_wr, ram_wr, mmio_wr;
    logic [31:0]       mmio_rd;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic [31:0]       mem [DEPTH];

    always_comb begin
        inst_phys = kseg_translate(inst_sram_addr);
        data_phys = kseg_translate(data_sram_addr);
        inst_idx  = inst_phys[ADDR_W+1:2];
        data_idx  = data_phys[ADDR_W+1:2];
        inst_mmio = (inst_phys[31:16] == MMIO_BASE[31:16]);
        data_mmio = (data_phys[31:16] == MMIO_BASE[31:16]);
        data_wr   = data_sram_en && (data_sram_wen != 4'b0000);
        ram_wr    = data_wr && !data_mmio;
        mmio_wr   = data_wr && data_mmio;
    end

    // Instruction port never reaches MMIO; its side-effect-free view there is 0.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (inst_sram_en) inst_rdata_d = inst_mmio ? 32'b0 : mem[inst_idx];
        if (data_sram_en) data_rdata_d = data_mmio ? mmio_rd : mem[data_idx];
    end

    // Non-blocking RAM update gives read-before-write on both ports for free.
    always_ff @(posedge clk) begin
        if (ram_wr) mem[data_idx] <= byte_merge(mem[data_idx], data_sram_wdata, data_sram_wen);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    sram_responder_mmio_regs u_mmio (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mmio_wr),
        .off      (data_phys[15:0]),
        .wen      (data_sram_wen),
        .wdata    (data_sram_wdata),
        .rd_data  (mmio_rd),
        .led      (led),
        .num_data (num_data),
        .sim_done (sim_done)
    );

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

    logic unused_bits;
    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_phys[1:0], data_phys[1:0]};

endmodule
